// File: rtl/pwm_capture_if.sv
`default_nettype none
// +--------------------------------------------------------------+
// | pwm_capture_if : PWM input and recovered-width result bundle |
// | Revision 1.0                                                 |
// +--------------------------------------------------------------+
interface pwm_capture_if;
  logic       pwm_in;
  logic [7:0] pw_out;
  logic       pw_valid;
  logic       frame_err;
  logic       locked;

  modport master (output pwm_in, input pw_out, pw_valid, frame_err, locked);
  modport slave  (input pwm_in, output pw_out, pw_valid, frame_err, locked);
endinterface
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// +--------------------------------------------------------------+
// | pwm_capture : recovers the 8-bit width of a 256-tick PWM     |
// | frame, flags bad frame periods and reports steady levels.    |
// | Revision 1.0                                                 |
// +--------------------------------------------------------------+
module pwm_capture #(
  parameter int PRESCALE      = 19,
  parameter int TIMEOUT_TICKS = 300
) (
  input  logic         clk,
  input  logic         rst,
  pwm_capture_if.slave bus
);
  localparam int                 PRESC_W        = $clog2(PRESCALE);
  localparam logic [PRESC_W-1:0] c_presc_last   = PRESC_W'(PRESCALE - 1);
  localparam logic [PRESC_W-1:0] c_presc_sample = PRESC_W'(PRESCALE / 2);
  localparam logic [8:0]         c_timeout      = 9'(TIMEOUT_TICKS);
  localparam logic [8:0]         c_win_lo       = 9'd254;
  localparam logic [8:0]         c_win_hi       = 9'd256;

  typedef enum logic [0:0] {
    ST_ARM  = 1'b0,
    ST_MEAS = 1'b1
  } state_t;

  logic               s1_q, s2_q, s3_q;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [7:0]         hi_cnt_q, hi_cnt_d;
  logic [8:0]         period_cnt_q, period_cnt_d;
  state_t             state_q, state_d;
  logic [7:0]         pw_out_q, pw_out_d;
  logic               pw_valid_q, pw_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               locked_q, locked_d;
  logic               w_rise;

  assign w_rise = s2_q & ~s3_q;

  always_comb begin
    presc_d      = presc_q;
    hi_cnt_d     = hi_cnt_q;
    period_cnt_d = period_cnt_q;
    state_d      = state_q;
    pw_out_d     = pw_out_q;
    pw_valid_d   = 1'b0;
    frame_err_d  = 1'b0;
    locked_d     = locked_q;

    if (presc_q == c_presc_last) begin
      presc_d = '0;
      if (period_cnt_q != 9'h1FF) period_cnt_d = period_cnt_q + 9'd1;
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end

    if (presc_q == c_presc_sample && s2_q && hi_cnt_q != 8'hFF)
      hi_cnt_d = hi_cnt_q + 8'd1;

    // A rise overrides both the free-running counts and any pending timeout.
    if (w_rise) begin
      presc_d      = '0;
      hi_cnt_d     = '0;
      period_cnt_d = '0;
      state_d      = ST_MEAS;
      if (state_q == ST_MEAS) begin
        if (period_cnt_q >= c_win_lo && period_cnt_q <= c_win_hi) begin
          pw_out_d   = hi_cnt_q;
          pw_valid_d = 1'b1;
          locked_d   = 1'b1;
        end else begin
          frame_err_d = 1'b1;
          locked_d    = 1'b0;
        end
      end
    end else if (period_cnt_q == c_timeout) begin
      presc_d      = '0;
      hi_cnt_d     = '0;
      period_cnt_d = '0;
      state_d      = ST_ARM;
      pw_out_d     = s2_q ? 8'hFF : 8'h00;
      pw_valid_d   = 1'b1;
      locked_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      presc_q      <= '0;
      hi_cnt_q     <= '0;
      period_cnt_q <= '0;
      state_q      <= ST_ARM;
      pw_out_q     <= '0;
      pw_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      s1_q         <= bus.pwm_in;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      presc_q      <= presc_d;
      hi_cnt_q     <= hi_cnt_d;
      period_cnt_q <= period_cnt_d;
      state_q      <= state_d;
      pw_out_q     <= pw_out_d;
      pw_valid_q   <= pw_valid_d;
      frame_err_q  <= frame_err_d;
      locked_q     <= locked_d;
    end
  end

  assign bus.pw_out    = pw_out_q;
  assign bus.pw_valid  = pw_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.locked    = locked_q;
endmodule
`default_nettype wire
